// File: rtl/slave_serial_port_pkg.sv
// Shared definitions for the slave serial port: default lengths, FSM state
// encoding, latched operation encoding and a small sizing helper.
package slave_serial_port_pkg;

  localparam int unsigned ADDR_LEN_DEF = 12;
  localparam int unsigned DATA_LEN_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_MEM_RD = 3'd4,
    ST_RD_CAP = 3'd5,
    ST_TX     = 3'd6
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Larger of two lengths, used to size the shared bit counter.
  function automatic int unsigned max_len(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_serial_port_if.sv
// Serial bus handshake between the interconnect slave port (master side)
// and the slave serial port.
//   master_valid/write_en/read_en : transaction framing and request type
//   rx_address/rx_data            : serial address / write data, LSB first
//   master_ready                  : master accepts read data
//   slave_ready/slave_valid       : port idle / read data valid
//   tx_data                       : serial read data, LSB first
interface slave_serial_port_if;

  logic master_valid;
  logic write_en;
  logic read_en;
  logic rx_address;
  logic rx_data;
  logic master_ready;
  logic slave_ready;
  logic slave_valid;
  logic tx_data;

  modport master (
    output master_valid, write_en, read_en, rx_address, rx_data, master_ready,
    input  slave_ready, slave_valid, tx_data
  );

  modport slave (
    input  master_valid, write_en, read_en, rx_address, rx_data, master_ready,
    output slave_ready, slave_valid, tx_data
  );

endinterface

// File: rtl/slave_serial_port_shift_reg.sv
// Right-shifting register: serial-in at the MSB / parallel-out, or
// parallel-load / serial-out at the LSB. Load has priority over shift.
//   clk, rst   : clock, async active-low clear
//   shift_en   : shift one position toward the LSB
//   load       : parallel load from pdata
//   sin        : serial input entering at the MSB
//   pdata      : parallel load data
//   q          : register contents (q[0] is the serial output)
module slave_serial_port_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= pdata;
    end else if (shift_en) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/slave_serial_port.sv
// Slave-side serial front end for a block RAM: deserialises address and
// write data, issues single-cycle RAM strobes and serialises read data.
//   clk, rst  : clock, async active-low reset
//   bus       : serial handshake (slave modport)
//   mem_addr  : RAM address      mem_wdata : RAM write data
//   mem_we    : write strobe     mem_re    : read strobe
//   mem_rdata : RAM read data, valid the cycle after mem_re
module slave_serial_port
  import slave_serial_port_pkg::*;
#(
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  slave_serial_port_if.slave  bus,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(max_len(ADDR_LEN, DATA_LEN));
  // Address bit 0 is taken in IDLE, so ADDR only counts the remaining bits.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic               acc_q, acc_d;
  logic               slave_ready_q, slave_valid_q;
  logic               addr_shift, wdata_shift, rd_load, rd_shift;
  logic [DATA_LEN-1:0] rd_q;
  logic [DATA_LEN-1:1] rd_hi_unused;

  // Next-state, counter and datapath-control decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    addr_shift  = 1'b0;
    wdata_shift = 1'b0;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.master_valid && (bus.write_en || bus.read_en)) begin
          addr_shift = 1'b1;
          op_d       = bus.write_en ? OP_WRITE : OP_READ;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!bus.master_valid) begin
          state_d = ST_IDLE;
        end else begin
          addr_shift = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            state_d = (op_q == OP_WRITE) ? ST_WDATA : ST_MEM_RD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WDATA: begin
        if (!bus.master_valid) begin
          state_d = ST_IDLE;
        end else begin
          wdata_shift = 1'b1;
          if (cnt_q == DATA_LAST) begin
            state_d = ST_MEM_WR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_MEM_WR: state_d = ST_IDLE;
      ST_MEM_RD: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rd_load = 1'b1;
        acc_d   = 1'b0;
        state_d = ST_TX;
      end
      ST_TX: begin
        // Bit 0 waits for master_ready; once accepted the word streams out.
        if (acc_q || bus.master_ready) begin
          rd_shift = 1'b1;
          acc_d    = 1'b1;
          if (cnt_q == DATA_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State register; strobes and handshake outputs registered from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= OP_READ;
      acc_q         <= 1'b0;
      slave_ready_q <= 1'b1;
      slave_valid_q <= 1'b0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      acc_q         <= acc_d;
      slave_ready_q <= (state_d == ST_IDLE);
      slave_valid_q <= (state_d == ST_TX);
      mem_we        <= (state_d == ST_MEM_WR);
      mem_re        <= (state_d == ST_MEM_RD);
    end
  end

  slave_serial_port_shift_reg #(.WIDTH(ADDR_LEN)) u_addr_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (addr_shift),
    .load     (1'b0),
    .sin      (bus.rx_address),
    .pdata    ('0),
    .q        (mem_addr)
  );

  slave_serial_port_shift_reg #(.WIDTH(DATA_LEN)) u_wdata_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (wdata_shift),
    .load     (1'b0),
    .sin      (bus.rx_data),
    .pdata    ('0),
    .q        (mem_wdata)
  );

  // Zeros shift in behind the read word, so the LSB is 0 whenever not in TX.
  slave_serial_port_shift_reg #(.WIDTH(DATA_LEN)) u_rdata_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (rd_shift),
    .load     (rd_load),
    .sin      (1'b0),
    .pdata    (mem_rdata),
    .q        (rd_q)
  );

  assign rd_hi_unused    = rd_q[DATA_LEN-1:1];
  assign bus.tx_data     = rd_q[0];
  assign bus.slave_ready = slave_ready_q;
  assign bus.slave_valid = slave_valid_q;

endmodule
